// File: rtl/tone_player.sv
// tone_player: plays one square-wave tone (or a rest) for a requested number
// of milliseconds.
//
// Ports
//   clk            sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   sound0..sound4 tone periods in microseconds (13 bits each)
//   sel            0..4 selects sound0..sound4, 5..7 selects a rest
//   duration_ms    play length in ms, captured together with start
//   start          play request, honoured only while idle and stop is low
//   stop           aborts a play in progress (no done pulse)
//   speaker        registered square-wave output
//   busy           registered, high while playing
//   done           registered one-cycle pulse on normal completion
module tone_player #(
  parameter int CYCLES_PER_US = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] sound0,
  input  logic [12:0] sound1,
  input  logic [12:0] sound2,
  input  logic [12:0] sound3,
  input  logic [12:0] sound4,
  input  logic [2:0]  sel,
  input  logic [9:0]  duration_ms,
  input  logic        start,
  input  logic        stop,
  output logic        speaker,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, PLAY} state_t;

  localparam logic [9:0] PRESC_MAX = 10'(CYCLES_PER_US - 1);
  localparam logic [9:0] US_MAX    = 10'd999;

  // Half period in microseconds; a zero result would never toggle, so clamp to 1.
  function automatic logic [11:0] half_of(input logic [12:0] period);
    logic [11:0] h;
    h = period[12:1];
    return (h == 12'd0) ? 12'd1 : h;
  endfunction

  state_t      state, state_nxt;
  logic [12:0] sel_period;
  logic [12:0] period_q;
  logic        rest_q;
  logic [9:0]  dur_q;
  logic [9:0]  presc;
  logic [11:0] half_cnt;
  logic [9:0]  us_cnt;
  logic [9:0]  ms_cnt;
  logic [11:0] half_eff;
  logic        accept, tick, toggle, us_wrap, finish;
  logic        speaker_nxt, busy_nxt, done_nxt;

  always_comb begin
    case (sel)
      3'd0:    sel_period = sound0;
      3'd1:    sel_period = sound1;
      3'd2:    sel_period = sound2;
      3'd3:    sel_period = sound3;
      3'd4:    sel_period = sound4;
      default: sel_period = 13'd0;
    endcase
  end

  always_comb begin
    half_eff    = half_of(period_q);
    accept      = (state == IDLE) && start && !stop;
    tick        = (state == PLAY) && (presc == PRESC_MAX);
    toggle      = tick && (half_cnt == half_eff - 12'd1);
    us_wrap     = tick && (us_cnt == US_MAX);
    // A zero duration finishes after a single PLAY cycle.
    finish      = (state == PLAY) &&
                  ((dur_q == 10'd0) || (us_wrap && (ms_cnt + 10'd1 == dur_q)));
    state_nxt   = state;
    speaker_nxt = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = PLAY;
      end
      PLAY: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (finish) begin
          // Completion wins over a coincident toggle: speaker returns to 0.
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          speaker_nxt = (toggle && !rest_q) ? ~speaker : speaker;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= 13'd0;
      rest_q   <= 1'b0;
      dur_q    <= 10'd0;
      presc    <= 10'd0;
      half_cnt <= 12'd0;
      us_cnt   <= 10'd0;
      ms_cnt   <= 10'd0;
      speaker  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      speaker <= speaker_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      if (state == IDLE) begin
        if (accept) begin
          period_q <= sel_period;
          rest_q   <= (sel > 3'd4);
          dur_q    <= duration_ms;
          presc    <= 10'd0;
          half_cnt <= 12'd0;
          us_cnt   <= 10'd0;
          ms_cnt   <= 10'd0;
        end
      end else begin
        presc <= tick ? 10'd0 : presc + 10'd1;
        if (tick) begin
          half_cnt <= toggle  ? 12'd0 : half_cnt + 12'd1;
          us_cnt   <= us_wrap ? 10'd0 : us_cnt + 10'd1;
          if (us_wrap) ms_cnt <= ms_cnt + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tone_player.sv
// Bench for tone_player with CYCLES_PER_US = 2. A behavioural model tracks
// each play as "clock edges since the start edge" and derives busy/done/speaker
// from tick counts; a compare process checks it every cycle, and directed
// scenarios add hand-computed literal expectations.
module tb_tone_player;
  localparam int C = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] sound0 = 13'd0, sound1 = 13'd0, sound2 = 13'd0, sound3 = 13'd0, sound4 = 13'd0;
  logic [2:0]  sel = 3'd0;
  logic [9:0]  duration_ms = 10'd0;
  logic        start = 1'b0, stop = 1'b0;
  logic        speaker, busy, done;

  int checks = 0;
  int errors = 0;

  tone_player #(.CYCLES_PER_US(C)) dut (
    .clk(clk), .rst_n(rst_n),
    .sound0(sound0), .sound1(sound1), .sound2(sound2), .sound3(sound3), .sound4(sound4),
    .sel(sel), .duration_ms(duration_ms), .start(start), .stop(stop),
    .speaker(speaker), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a play is "active" from its start edge; n counts edges since then.
  bit m_active = 0, m_rest = 0, m_done = 0;
  int m_n = 0, m_end = 0, m_half = 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_n = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_active) begin
        m_n++;
        if (stop) m_active = 0;
        else if (m_n == m_end) begin m_active = 0; m_done = 1; end
      end else if (start && !stop) begin
        int p;
        case (sel)
          3'd0: p = sound0;
          3'd1: p = sound1;
          3'd2: p = sound2;
          3'd3: p = sound3;
          3'd4: p = sound4;
          default: p = 0;
        endcase
        m_active = 1;
        m_n      = 0;
        m_rest   = (sel > 3'd4);
        m_half   = (p / 2 == 0) ? 1 : p / 2;
        m_end    = (duration_ms == 0) ? 1 : int'(duration_ms) * 1000 * C;
      end
    end
  end

  always @(negedge clk) begin
    int exp_spk;
    exp_spk = (m_active && !m_rest) ? (((m_n / C) / m_half) % 2) : 0;
    check("busy", int'(busy), int'(m_active));
    check("done", int'(done), int'(m_done));
    check("speaker", int'(speaker), exp_spk);
  end

  // Starts a play from the current negedge and samples each following negedge.
  // poke_k: cycle at which a second start (sel=3) is pulsed; stop_k: cycle at
  // which stop is raised (the task returns one cycle later).
  task automatic run_play(input logic [2:0] s, input logic [9:0] d, input int limit,
                          input int poke_k, input int stop_k, input bit want_done,
                          output int done_k, output int busy_cnt,
                          output int trans, output int first_rise);
    logic prev;
    sel = s; duration_ms = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    prev = speaker; trans = 0; first_rise = -1; done_k = -1;
    for (int k = 1; k <= limit; k++) begin
      if (k == poke_k + 1) start = 1'b0;
      @(negedge clk);
      if (speaker != prev) begin
        trans++;
        if (speaker && first_rise < 0) first_rise = k;
      end
      prev = speaker;
      if (busy) busy_cnt++;
      if (done) begin done_k = k; break; end
      if (k == stop_k + 1) begin stop = 1'b0; break; end
      if (k == poke_k) begin start = 1'b1; sel = 3'd3; end
      if (k == stop_k) stop = 1'b1;
    end
    start = 1'b0;
    if (want_done && done_k < 0) check("done_timeout", 0, 1);
  endtask

  initial begin
    int dk, bc, tr, fr, dcount;
    sound0 = 13'd5000; sound1 = 13'd80; sound2 = 13'd2500; sound3 = 13'd100; sound4 = 13'd1;

    #1;
    check("reset_speaker", int'(speaker), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Stop alone and start+stop together in IDLE do nothing.
    stop = 1'b1; @(negedge clk);
    start = 1'b1; @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("idle_start_stop_busy", int'(busy), 0);
    @(negedge clk);
    check("idle_start_stop_busy2", int'(busy), 0);

    // 2500 us tone, 3 ms: half period 1250 ticks = 2500 clk, done 6000 clk after start.
    run_play(3'd2, 10'd3, 7000, -1, -1, 1, dk, bc, tr, fr);
    check("tone_done_cycle", dk, 6000);
    check("tone_first_rise", fr, 2500);
    check("tone_transitions", tr, 2);
    check("tone_busy_cycles", bc, 6000);
    @(negedge clk);
    check("tone_busy_after", int'(busy), 0);

    // Rest for 1 ms: 2000 busy cycles, no speaker activity.
    run_play(3'd6, 10'd1, 3000, -1, -1, 1, dk, bc, tr, fr);
    check("rest_done_cycle", dk, 2000);
    check("rest_busy_cycles", bc, 2000);
    check("rest_transitions", tr, 0);

    // Zero duration, started in the done cycle of the previous play.
    run_play(3'd0, 10'd0, 10, -1, -1, 1, dk, bc, tr, fr);
    check("zero_done_cycle", dk, 1);
    check("zero_busy_cycles", bc, 1);
    check("zero_transitions", tr, 0);
    @(negedge clk);
    check("zero_done_once", int'(done), 0);

    // Stop at clk 3001 of a 10 ms play.
    run_play(3'd0, 10'd10, 4000, -1, 3000, 0, dk, bc, tr, fr);
    check("stop_no_done", dk, -1);
    check("stop_busy", int'(busy), 0);
    check("stop_speaker", int'(speaker), 0);
    check("stop_done", int'(done), 0);
    dcount = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (done) dcount++; end
    check("stop_no_late_done", dcount, 0);

    // Period 80 (half 40 ticks), 1 ms, restart attempt with sel=3 mid-play.
    // Toggle 25 would coincide with completion and must lose to it.
    run_play(3'd1, 10'd1, 3000, 100, -1, 1, dk, bc, tr, fr);
    check("ignore_done_cycle", dk, 2000);
    check("ignore_first_rise", fr, 80);
    check("ignore_transitions", tr, 24);
    check("ignore_speaker_at_done", int'(speaker), 0);

    // Period 1: half clamps to 1, toggle on every tick.
    @(negedge clk);
    run_play(3'd4, 10'd1, 3000, -1, -1, 1, dk, bc, tr, fr);
    check("p1_first_rise", fr, 2);
    check("p1_transitions", tr, 1000);
    check("p1_done_cycle", dk, 2000);

    // Max period 8191: half 4095 ticks.
    sound2 = 13'd8191;
    @(negedge clk);
    run_play(3'd2, 10'd5, 11000, -1, -1, 1, dk, bc, tr, fr);
    check("max_first_rise", fr, 8190);
    check("max_transitions", tr, 2);
    check("max_done_cycle", dk, 10000);

    // Reset mid-play while speaker is high (period 4: high on cycles 4..7).
    sound0 = 13'd4;
    @(negedge clk);
    sel = 3'd0; duration_ms = 10'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("prereset_speaker", int'(speaker), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_speaker", int'(speaker), 0);
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (done || busy) dcount++; end
    check("post_reset_idle", dcount, 0);
    run_play(3'd0, 10'd1, 3000, -1, -1, 1, dk, bc, tr, fr);
    check("post_reset_done_cycle", dk, 2000);
    check("post_reset_first_rise", fr, 4);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
